// File: rtl/mul16_seq_if.sv
// rtl/mul16_seq_if.sv - operand/product handshake bundle for mul16_seq
interface mul16_seq_if;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] product;
   logic        busy;

   // Producer/consumer side: issues operands and accepts products
   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, product, busy
   );

   // Multiplier side
   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, product, busy
   );
endinterface

// File: rtl/mul16_seq.sv
// rtl/mul16_seq.sv - sequential 16-bit shift-and-add multiplier (low half of a*b)

// 16-bit adder; the carry out of bit 15 is dropped, so sums wrap mod 2^16
module add16 (
   input  logic [15:0] x,
   input  logic [15:0] y,
   output logic [15:0] sum
);
   assign sum = x + y;
endmodule

module mul16_seq #(
   parameter bit EARLY_OUT = 1'b0
) (
   input logic        clk,
   input logic        rst_n,
   mul16_seq_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [15:0] acc;
   logic [15:0] mcand;
   logic [15:0] mplier;
   logic [15:0] sum;
   logic [3:0]  cnt;
   logic        last_step;

   add16 u_add (
      .x   (acc),
      .y   (mcand),
      .sum (sum)
   );

   // The step in progress is the last one after sixteen steps, or, with early
   // exit enabled, once the multiplier has no set bits left above bit 0.
   assign last_step = (cnt == 4'd15) || (EARLY_OUT && (mplier[15:1] == 15'd0));

   // Product is always the accumulator; it only changes in RUN, so it is
   // stable for the whole of DONE.
   assign bus.product = acc;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and handshake outputs; outputs decode state only, so there is
   // no combinational path from in_valid or out_ready to the handshakes.
   always_comb begin
      state_nxt     = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.busy      = 1'b0;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            bus.busy = 1'b1;
            if (last_step) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            bus.busy      = 1'b1;
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Datapath: capture operands on accept, then one conditional add and shift per step
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  mplier <= bus.a;
                  mcand  <= bus.b;
                  acc    <= '0;
                  cnt    <= '0;
               end
            end
            RUN: begin
               if (mplier[0]) begin
                  acc <= sum;
               end
               mcand  <= {mcand[14:0], 1'b0};
               mplier <= {1'b0, mplier[15:1]};
               cnt    <= cnt + 4'd1;
            end
            default: begin
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mul16_seq.sv
// tb/tb_mul16_seq.sv - scoreboard bench for mul16_seq in fixed-latency and early-exit builds
module tb_mul16_seq;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mul16_seq_if bus0 ();
   mul16_seq_if bus1 ();

   mul16_seq #(.EARLY_OUT(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   mul16_seq #(.EARLY_OUT(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp0[$];
   logic [15:0] exp1[$];
   bit          rand_on;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor for dut0: products checked against the scoreboard, held output checked while stalled
   logic        pv0, pr0;
   logic [15:0] pp0;
   always @(negedge clk) begin
      if (!rst_n) begin
         pv0 <= 1'b0;
         pr0 <= 1'b0;
      end else begin
         if (pv0 && !pr0) begin
            check("dut0 hold out_valid", bus0.out_valid, 1);
            check("dut0 hold product", bus0.product, pp0);
         end
         if (bus0.out_valid && bus0.out_ready) begin
            if (exp0.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL dut0 unexpected product: got 0x%0h expected none", bus0.product);
            end else begin
               check("dut0 product", bus0.product, exp0.pop_front());
            end
         end
         pv0 <= bus0.out_valid;
         pr0 <= bus0.out_ready;
         pp0 <= bus0.product;
      end
   end

   // Monitor for dut1 (early exit build)
   logic        pv1, pr1;
   logic [15:0] pp1;
   always @(negedge clk) begin
      if (!rst_n) begin
         pv1 <= 1'b0;
         pr1 <= 1'b0;
      end else begin
         if (pv1 && !pr1) begin
            check("dut1 hold out_valid", bus1.out_valid, 1);
            check("dut1 hold product", bus1.product, pp1);
         end
         if (bus1.out_valid && bus1.out_ready) begin
            if (exp1.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL dut1 unexpected product: got 0x%0h expected none", bus1.product);
            end else begin
               check("dut1 product", bus1.product, exp1.pop_front());
            end
         end
         pv1 <= bus1.out_valid;
         pr1 <= bus1.out_ready;
         pp1 <= bus1.product;
      end
   end

   // Present operands until accepted; returns just after the accept edge E0
   task automatic send(input bit sel, input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] exp, input bit push);
      int n = 0;
      @(posedge clk);
      #1;
      if (sel) begin
         bus1.a = x; bus1.b = y; bus1.in_valid = 1'b1;
         if (push) exp1.push_back(exp);
      end else begin
         bus0.a = x; bus0.b = y; bus0.in_valid = 1'b1;
         if (push) exp0.push_back(exp);
      end
      do begin
         @(negedge clk);
         n++;
      end while (!(sel ? bus1.in_ready : bus0.in_ready) && n < 300);
      if (!(sel ? bus1.in_ready : bus0.in_ready)) begin
         checks++;
         errors++;
         $display("FAIL dut%0d accept timeout: in_ready low for %0d cycles", sel, n);
      end
      @(posedge clk);
      #1;
      if (sel) begin
         bus1.in_valid = 1'b0; bus1.a = 16'($urandom); bus1.b = 16'($urandom);
      end else begin
         bus0.in_valid = 1'b0; bus0.a = 16'($urandom); bus0.b = 16'($urandom);
      end
   endtask

   // Count edges after E0 until out_valid first appears
   task automatic latency(input bit sel, input int k, input string name);
      int n = 0;
      @(negedge clk);
      check({name, " in_ready after accept"}, sel ? bus1.in_ready : bus0.in_ready, 0);
      check({name, " busy after accept"}, sel ? bus1.busy : bus0.busy, 1);
      do begin
         @(negedge clk);
         n++;
      end while (!(sel ? bus1.out_valid : bus0.out_valid) && n < 40);
      check({name, " latency"}, n, k);
   endtask

   initial begin
      #5_000_000;
      errors++;
      $display("FAIL watchdog: simulation still running at time %0t", $time);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      rst_n = 1'b0;
      bus0.in_valid = 1'b0; bus0.a = '0; bus0.b = '0; bus0.out_ready = 1'b1;
      bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("reset in_ready", {bus1.in_ready, bus0.in_ready}, 2'b11);
      check("reset out_valid", {bus1.out_valid, bus0.out_valid}, 2'b00);
      check("reset busy", {bus1.busy, bus0.busy}, 2'b00);
      check("reset product0", bus0.product, 0);
      check("reset product1", bus1.product, 0);

      // Basic 3*5 with full handshake timing
      send(0, 16'd3, 16'd5, 16'h000F, 1);
      latency(0, 16, "t1");
      check("t1 in_ready in DONE", bus0.in_ready, 0);
      @(negedge clk);
      check("t1 in_ready after handshake", bus0.in_ready, 1);
      check("t1 out_valid after handshake", bus0.out_valid, 0);

      // Signed-looking operands and wrap
      send(0, 16'hFFFF, 16'hFFFF, 16'h0001, 1);
      latency(0, 16, "t2a");
      send(0, 16'hFFFD, 16'h0007, 16'hFFEB, 1);
      latency(0, 16, "t2b");
      send(0, 16'h0100, 16'h0100, 16'h0000, 1);
      latency(0, 16, "t2c");

      // Consumer stall in DONE with ignored operand pulses
      @(posedge clk);
      #1 bus0.out_ready = 1'b0;
      send(0, 16'd7, 16'd6, 16'h002A, 1);
      latency(0, 16, "t3");
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         bus0.in_valid = (i % 2 == 0);
         bus0.a = 16'd9;
         bus0.b = 16'd9;
         @(negedge clk);
         check("t3 in_ready in stall", bus0.in_ready, 0);
         check("t3 busy in stall", bus0.busy, 1);
      end
      @(posedge clk);
      #1;
      bus0.in_valid = 1'b0;
      bus0.out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("t3 in_ready after handshake", bus0.in_ready, 1);
      send(0, 16'd4, 16'd5, 16'h0014, 1);
      latency(0, 16, "t3b");

      // Asynchronous reset in the middle of RUN
      send(0, 16'h1234, 16'h5678, 16'h0000, 0);
      repeat (7) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("t4 product in reset", bus0.product, 0);
      check("t4 out_valid in reset", bus0.out_valid, 0);
      check("t4 busy in reset", bus0.busy, 0);
      #3 rst_n = 1'b1;
      send(0, 16'd2, 16'd3, 16'h0006, 1);
      latency(0, 16, "t4");

      // Early exit latency
      send(1, 16'd2, 16'h0041, 16'h0082, 1);
      latency(1, 2, "e1");
      send(1, 16'd0, 16'hBEEF, 16'h0000, 1);
      latency(1, 1, "e2");
      send(1, 16'h8000, 16'h0001, 16'h8000, 1);
      latency(1, 16, "e3");

      // Random stream on both builds with input and output stalls
      rand_on = 1'b1;
      fork
         begin
            fork
               for (int i = 0; i < 1000; i++) begin
                  automatic logic [15:0] x = 16'($urandom);
                  automatic logic [15:0] y = 16'($urandom);
                  automatic logic [31:0] f = x * y;
                  repeat ($urandom_range(0, 2)) @(posedge clk);
                  send(0, x, y, f[15:0], 1);
               end
               for (int j = 0; j < 1000; j++) begin
                  automatic logic [15:0] x = 16'($urandom);
                  automatic logic [15:0] y = 16'($urandom);
                  automatic logic [31:0] f = x * y;
                  repeat ($urandom_range(0, 2)) @(posedge clk);
                  send(1, x, y, f[15:0], 1);
               end
            join
            rand_on = 1'b0;
         end
         while (rand_on) begin
            @(posedge clk);
            #1;
            bus0.out_ready = ($urandom_range(0, 3) != 0);
            bus1.out_ready = ($urandom_range(0, 3) != 0);
         end
      join
      @(posedge clk);
      #1;
      bus0.out_ready = 1'b1;
      bus1.out_ready = 1'b1;
      n = 0;
      while ((exp0.size() != 0 || exp1.size() != 0) && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("dut0 drained", exp0.size(), 0);
      check("dut1 drained", exp1.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mul16_seq.md
Name: mul16_seq

Overview:
- Sequential 16-bit shift-and-add multiplier for the Hack-style CPU datapath.
- Produces the low 16 bits of a*b. This result is identical for signed (two's complement) and unsigned operands.
- Owns one add16 instance and sequences it: one conditional accumulate per cycle, under a small FSM with valid/ready handshakes on both input and output.
- Sits beside the ALU as a multi-cycle functional unit.

Parameters:
- EARLY_OUT, 0, 1 = leave RUN as soon as the remaining multiplier is zero; 0 = fixed 16 compute steps.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a, b are valid
- in_ready  output  1  unit can accept operands; high only in IDLE
- a  input  16  multiplier operand (consumed LSB first)
- b  input  16  multiplicand operand
- out_valid  output  1  product is valid; high only in DONE
- out_ready  input  1  consumer accepts the product
- product  output  16  low 16 bits of a*b, held stable while out_valid is high
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state=IDLE.
  - Internal acc, mcand, mplier and step counter cleared to 0.
  - product=0, out_valid=0, busy=0, in_ready=1 (from the cycle after deassertion onward).
- Reset mid-RUN or mid-DONE abandons the operation. Nothing is emitted.
- Registers: acc[15:0], mcand[15:0], mplier[15:0], cnt[3:0], state[1:0]. product is driven directly from acc.
- IDLE:
  - in_ready=1.
  - On the edge where in_valid && in_ready: mplier<=a, mcand<=b, acc<=0, cnt<=0, state<=RUN.
  - Otherwise hold.
- RUN (in_ready=0, busy=1), one step per edge:
  - acc <= mplier[0] ? add16(acc, mcand) : acc.
  - mcand <= mcand<<1 (zero fill; bit 15 discarded).
  - mplier <= mplier>>1 (logical shift).
  - cnt <= cnt+1.
- RUN exit:
  - Go to DONE after the step with cnt==15.
  - If EARLY_OUT=1, also go to DONE after any step whose shifted mplier (mplier>>1) is zero.
- Arithmetic:
  - All sums are mod 2^16. add16 has no carry-out; overflow is silently discarded.
  - No overflow flag.
- DONE:
  - out_valid=1; product=acc, stable.
  - On the edge where out_valid && out_ready: state<=IDLE, out_valid falls.
  - in_ready stays 0 throughout DONE, including the handshake cycle. No same-cycle accept; the next accept is at the earliest one cycle later.
- Latency, counting the accept edge as E0:
  - EARLY_OUT=0: fixed. out_valid first high after edge E16.
  - EARLY_OUT=1: out_valid high after edge Ek, where k = max(1, index of the highest set bit of a + 1). For a=0, k=1.
- Throughput (EARLY_OUT=0) with out_ready tied high: one result every 18 cycles (1 IDLE + 16 RUN + 1 DONE).
- Inputs while busy:
  - in_valid and a/b are ignored in RUN and DONE.
  - Operands are captured only at the accept edge; later changes to a/b have no effect.
- out_ready outside DONE has no effect.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Test Plan:
- Reset, then a=3, b=5, EARLY_OUT=0, out_ready=1 -> in_ready drops after E0; out_valid high after E16 with product=0x000F; in_ready high again one cycle after the handshake.
- a=0xFFFF, b=0xFFFF -> product=0x0001. Then a=0xFFFD (-3), b=7 -> product=0xFFEB (-21). Then a=0x0100, b=0x0100 -> product=0x0000 (wrap).
- out_ready held low for 10 cycles after out_valid -> product and out_valid stable, state stays DONE; in_valid pulses with a=9, b=9 during that window are ignored; out_ready=1 -> handshake, next accept takes the new operands.
- rst_n pulsed low asynchronously (mid-cycle) at step 7 of a=0x1234, b=0x5678 -> outputs clear immediately to product=0, out_valid=0, busy=0; no result is emitted; next operation a=2, b=3 gives 0x0006.
- EARLY_OUT=1: a=2, b=0x0041 -> out_valid after E2, product=0x0082. a=0, b=0xBEEF -> out_valid after E1, product=0x0000. a=0x8000, b=1 -> after E16, product=0x8000.
- Back-to-back random stream of 1000 operand pairs with random in_valid/out_ready stalls -> every product equals (a*b) mod 2^16 from a reference model; no operation dropped or duplicated.
